calc_alu_sequencer: RTL and testbench

Multi-cycle arithmetic engine for the simple calculator. It accepts one operation request (add, subtract, multiply, divide) on two 16-bit operands from the calculator state machine, then sequences an iterative shift-add multiplier or restoring divider. It returns a registered 17-bit result, a remainder and an error flag through a Start/Busy/Done handshake. It sits between the operand-entry FSM and the VGA/SSD output path, replacing single-cycle combinational `*` and `/`.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_iter_datapath.sv | 100 ++++++++++
 rtl/calc_alu_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator arithmetic engine.
//   WIDTH   - default operand width (result is WIDTH+1 bits)
//   op_e    - operation encodings carried on the 2-bit op input
//   state_e - sequencer FSM states
package calc_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddSub,
    StMul,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/calc_iter_datapath.sv
// calc_iter_datapath: shared iterative datapath for the shift-add multiplier and
// the restoring divider. One step per clock while step_i is high.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   load_i        - clear accumulator, load shift register with a_i
//   step_i        - perform one multiply or divide iteration
//   div_mode_i    - step is a divide iteration (only when CALC_DIV_EN is defined)
//   a_i, b_i      - load operand / iteration operand (held stable while stepping)
//   hi_o, lo_o    - accumulator and shift register
//                   mul: product = {hi_o, lo_o}; div: quotient = lo_o, remainder = hi_o
// Build option: CALC_DIV_EN compiles in the divide iteration.
module calc_iter_datapath
  import calc_pkg::*;
#(
  parameter int unsigned Width = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
`ifdef CALC_DIV_EN
  input  logic             div_mode_i,
`endif
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

`ifdef CALC_DIV_EN
  // Extra bit carries the borrow of the divide trial subtraction.
  localparam int unsigned AdderW = Width + 2;
`else
  localparam int unsigned AdderW = Width + 1;
`endif

  logic [Width-1:0]  acc_q, acc_d;
  logic [Width-1:0]  sh_q, sh_d;
  logic [AdderW-1:0] add_x, add_y, add_r;
  logic [Width:0]    mul_t;

  // Shared adder/subtractor.
  always_comb begin
    add_x = {{(AdderW - Width){1'b0}}, acc_q};
    add_y = {{(AdderW - Width){1'b0}}, b_i};
`ifdef CALC_DIV_EN
    if (div_mode_i) begin
      // Trial subtract of the divisor from the partial remainder shifted left by one.
      add_x = {1'b0, acc_q, sh_q[Width-1]};
      add_r = add_x - add_y;
    end else begin
      add_r = add_x + add_y;
    end
`else
    add_r = add_x + add_y;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    // Multiply: conditionally add b to the high half, then shift the 2*Width pair right.
    mul_t = sh_q[0] ? add_r[Width:0] : {1'b0, acc_q};
    if (load_i) begin
      acc_d = '0;
      sh_d  = a_i;
    end else if (step_i) begin
`ifdef CALC_DIV_EN
      if (div_mode_i) begin
        if (!add_r[AdderW-1]) begin
          acc_d = add_r[Width-1:0];
          sh_d  = {sh_q[Width-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[Width-2:0], sh_q[Width-1]};
          sh_d  = {sh_q[Width-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_t[Width:1];
        sh_d  = {mul_t[0], sh_q[Width-1:1]};
      end
`else
      acc_d = mul_t[Width:1];
      sh_d  = {mul_t[0], sh_q[Width-1:1]};
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sh_q  <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
    end
  end

  assign hi_o = acc_q;
  assign lo_o = sh_q;

endmodule

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle add/sub/mul/div engine with a start/busy/done
// handshake. Add and sub complete in one step; mul and div iterate Width cycles
// through calc_iter_datapath. All outputs are registered.
//   clk_i, rst_i  - clock, asynchronous active-high reset (clears every output)
//   start_i       - request pulse, sampled only in idle
//   clear_i       - synchronous abort back to idle, no done; outputs keep last values
//   op_i, a_i, b_i- operation and operands, sampled with start_i
//   busy_o        - operation in progress
//   done_o        - one-cycle pulse, c_o/rem_o/flag_o valid from this cycle
//   c_o           - Width+1-bit result
//   rem_o         - division remainder, 0 for other operations
//   flag_o        - divide by zero, multiply overflow or disabled operation
// Build option: CALC_DIV_EN enables the restoring divider; without it a divide
// request finishes immediately with flag_o=1 and rem_o is tied to zero.
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned Width = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width:0]   c_o,
  output logic [Width-1:0] rem_o,
  output logic             flag_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [Width:0]   c_q, c_d;
  logic             flag_q, flag_d;
`ifdef CALC_DIV_EN
  logic [Width-1:0] rem_q, rem_d;
  logic             div_mode;
`endif

  logic             dp_load;
  logic             dp_step;
  logic [Width-1:0] dp_hi;
  logic [Width-1:0] dp_lo;

  calc_iter_datapath #(
    .Width(Width)
  ) u_datapath (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dp_load),
    .step_i     (dp_step),
`ifdef CALC_DIV_EN
    .div_mode_i (div_mode),
`endif
    .a_i        (a_i),
    .b_i        (b_q),
    .hi_o       (dp_hi),
    .lo_o       (dp_lo)
  );

`ifdef CALC_DIV_EN
  assign div_mode = (state_q == StDiv);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    flag_d  = flag_q;
`ifdef CALC_DIV_EN
    rem_d   = rem_q;
`endif
    dp_load = 1'b0;
    dp_step = 1'b0;

    if (clear_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_d    = op_e'(op_i);
            a_d     = a_i;
            b_d     = b_i;
            cnt_d   = '0;
            busy_d  = 1'b1;
            dp_load = 1'b1;
            case (op_e'(op_i))
              OP_MUL:  state_d = StMul;
`ifdef CALC_DIV_EN
              // Divide by zero skips iteration and finishes on single-step timing.
              OP_DIV:  state_d = (b_i == '0) ? StAddSub : StDiv;
`endif
              default: state_d = StAddSub;
            endcase
          end
        end

        StAddSub: begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          flag_d  = 1'b0;
`ifdef CALC_DIV_EN
          rem_d   = '0;
`endif
          case (op_q)
            OP_ADD:  c_d = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  c_d = {1'b0, a_q} - {1'b0, b_q};
            default: begin
              // Divide by zero, or divide when the divider is not built.
              c_d    = '0;
              flag_d = 1'b1;
`ifdef CALC_DIV_EN
              rem_d  = a_q;
`endif
            end
          endcase
        end

        StMul: begin
          if (cnt_q == CntW'(Width)) begin
            state_d = StDone;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            c_d     = {dp_hi[0], dp_lo};
            flag_d  = |dp_hi[Width-1:1];
`ifdef CALC_DIV_EN
            rem_d   = '0;
`endif
          end else begin
            dp_step = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end

        StDiv: begin
`ifdef CALC_DIV_EN
          if (cnt_q == CntW'(Width)) begin
            state_d = StDone;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            c_d     = {1'b0, dp_lo};
            flag_d  = 1'b0;
            rem_d   = dp_hi;
          end else begin
            dp_step = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
`else
          state_d = StIdle;
          busy_d  = 1'b0;
`endif
        end

        StDone: state_d = StIdle;

        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      flag_q  <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      flag_q  <= flag_d;
`ifdef CALC_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign c_o    = c_q;
  assign flag_o = flag_q;
`ifdef CALC_DIV_EN
  assign rem_o  = rem_q;
`else
  assign rem_o  = '0;
`endif

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Bench for calc_alu_sequencer: directed vector table, randomized operations
// against an arithmetic reference model, and handshake corner sequences
// (reset mid-multiply, clear mid-multiply, start while busy or done).
module tb_calc_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [16:0] c;
  logic [15:0] rem;
  logic        flag;

  int checks   = 0;
  int failures = 0;

  calc_alu_sequencer dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .clear_i (clear),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .c_o     (c),
    .rem_o   (rem),
    .flag_o  (flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] c;
    logic [15:0] rem;
    logic        flag;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic; lat is edges from the
  // accepting edge to the edge after which done is visible.
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [16:0] ec, output logic [15:0] er,
                                output logic ef, output int lat);
    int unsigned xi;
    int unsigned yi;
    int unsigned p;
    xi  = 32'(x);
    yi  = 32'(y);
    ec  = '0;
    er  = '0;
    ef  = 1'b0;
    lat = 1;
    case (o)
      2'd0: ec = 17'(xi + yi);
      2'd1: ec = 17'(xi - yi);
      2'd2: begin
        p   = xi * yi;
        ec  = 17'(p);
        ef  = (p >> 17) != 0;
        lat = 17;
      end
      default: begin
`ifdef CALC_DIV_EN
        if (yi == 0) begin
          er = x;
          ef = 1'b1;
        end else begin
          ec  = 17'(xi / yi);
          er  = 16'(xi % yi);
          lat = 17;
        end
`else
        ef = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [16:0] ec, input logic [15:0] er,
                        input logic ef, input int elat);
    int          lat;
    logic [16:0] c0;
    logic        hold_ok;
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    c0    = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs to prove the operands were latched.
    op    = 2'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    lat     = 0;
    hold_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (c !== c0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " c"}, 32'(c), 32'(ec));
    chk({tag, " rem"}, 32'(rem), 32'(er));
    chk({tag, " flag"}, 32'(flag), 32'(ef));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " hold_while_busy"}, 32'(hold_ok), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] ec;
    logic [15:0] er;
    logic        ef;
    int          el;
    int          ndone;
    logic [16:0] cap_c;
    logic        armed;

    vecs[0]  = '{2'd0, 16'hFFFF, 16'h0001, 17'h10000, 16'h0, 1'b0, 1};
    vecs[1]  = '{2'd1, 16'h0003, 16'h0005, 17'h1FFFE, 16'h0, 1'b0, 1};
    vecs[2]  = '{2'd2, 16'h0012, 16'h0034, 17'h003A8, 16'h0, 1'b0, 17};
    vecs[3]  = '{2'd2, 16'h1000, 16'h0100, 17'h00000, 16'h0, 1'b1, 17};
`ifdef CALC_DIV_EN
    vecs[4]  = '{2'd3, 16'h00FF, 16'h0010, 17'h0000F, 16'h000F, 1'b0, 17};
    vecs[5]  = '{2'd3, 16'h1234, 16'h0000, 17'h00000, 16'h1234, 1'b1, 1};
    vecs[6]  = '{2'd3, 16'hFFFF, 16'h0001, 17'h0FFFF, 16'h0000, 1'b0, 17};
`else
    vecs[4]  = '{2'd3, 16'h00FF, 16'h0010, 17'h00000, 16'h0000, 1'b1, 1};
    vecs[5]  = '{2'd3, 16'h1234, 16'h0000, 17'h00000, 16'h0000, 1'b1, 1};
    vecs[6]  = '{2'd3, 16'hFFFF, 16'h0001, 17'h00000, 16'h0000, 1'b1, 1};
`endif
    vecs[7]  = '{2'd0, 16'h1234, 16'h4321, 17'h05555, 16'h0, 1'b0, 1};
    vecs[8]  = '{2'd2, 16'hFFFF, 16'hFFFF, 17'h00001, 16'h0, 1'b1, 17};
    vecs[9]  = '{2'd2, 16'h8000, 16'h0002, 17'h10000, 16'h0, 1'b0, 17};
    vecs[10] = '{2'd1, 16'h0000, 16'h0000, 17'h00000, 16'h0, 1'b0, 1};

    rst   = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset c", 32'(c), 32'd0);
    chk("reset rem", 32'(rem), 32'd0);
    chk("reset flag", 32'(flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rem,
             vecs[i].flag, vecs[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra;
      logic [15:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      if (ro == 2'd3 && $urandom_range(0, 5) == 0) rb = '0;
      model(ro, ra, rb, ec, er, ef, el);
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ec, er, ef, el);
    end

    // Reset at iteration 8 of a multiply clears every output asynchronously.
    run_op("pre_reset add", 2'd0, 16'd5, 16'd6, 17'd11, 16'd0, 1'b0, 1);
    @(negedge clk);
    op = 2'd2; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset c", 32'(c), 32'd0);
    chk("midreset rem", 32'(rem), 32'd0);
    chk("midreset flag", 32'(flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midreset no_done", 32'(ndone), 32'd0);
    run_op("post_reset mul", 2'd2, 16'd300, 16'd200, 17'd60000, 16'd0, 1'b0, 17);

    // Clear at iteration 5: no done, previous result retained.
    run_op("pre_clear add", 2'd0, 16'd5, 16'd6, 17'd11, 16'd0, 1'b0, 1);
    @(negedge clk);
    op = 2'd2; a = 16'h00AB; b = 16'h00CD; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("clear no_done", 32'(ndone), 32'd0);
    chk("clear c_kept", 32'(c), 32'd11);
    run_op("post_clear sub", 2'd1, 16'd100, 16'd1, 17'd99, 16'd0, 1'b0, 1);

    // Start while busy and again while in done: both ignored.
    @(negedge clk);
    op = 2'd2; a = 16'd3; b = 16'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = 2'd0; a = 16'd1; b = 16'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    cap_c = '0;
    armed = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        cap_c = c;
        if (!armed) begin
          armed = 1'b1;
          op = 2'd0; a = 16'd1; b = 16'd1; start = 1'b1;
        end
      end
    end
    chk("busy_start single_done", 32'(ndone), 32'd1);
    chk("busy_start c", 32'(cap_c), 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
